reg_bus_master: RTL and testbench

Register-bus initiator that drives the per-bit register bank write interface (`wrb`, one-hot register select, write data) and reads back the bank's `rdout`. It accepts single read or write commands from a control sequencer over a valid/ready handshake, runs the bus cycle with a programmable strobe width, and returns one response per command. It sits between the configuration sequencer and the register bank, one instance per bank.

---
 rtl/reg_bus_pkg.sv | 21 ++
 rtl/reg_bus_wait_cnt.sv | 39 +++
 rtl/reg_bus_master.sv | 173 +++++++++++++++++
 tb/tb_reg_bus_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared state encoding and counter constants for the register-bus master.
`default_nettype none

package reg_bus_pkg;

    localparam int RB_STROBE_MAX = 15;
    localparam int RB_CNT_W      = 4;

    typedef logic [2:0] rb_state_t;

    localparam rb_state_t ST_IDLE   = 3'd0;
    localparam rb_state_t ST_SETUP  = 3'd1;
    localparam rb_state_t ST_STROBE = 3'd2;
    localparam rb_state_t ST_HOLD   = 3'd3;
    localparam rb_state_t ST_WAIT   = 3'd4;
    localparam rb_state_t ST_RESP   = 3'd5;
    localparam rb_state_t ST_VERIFY = 3'd6;

endpackage

`default_nettype wire

// File: rtl/reg_bus_wait_cnt.sv
// reg_bus_wait_cnt: loadable down-counter timing the STROBE, WAIT and VERIFY phases.
`default_nettype none

module reg_bus_wait_cnt
    import reg_bus_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [RB_CNT_W-1:0] load_val_i,
    input  logic                en_i,
    output logic                done_o
);

    logic [RB_CNT_W-1:0] cnt_q;
    logic [RB_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/reg_bus_master.sv
// reg_bus_master: valid/ready command initiator driving a register bank write/read bus.
// Optional write read-back check enabled by defining REG_MASTER_READBACK_EN.
`default_nettype none

module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int bus_width     = 15,
    parameter int NUM_REGS      = 31,
    parameter int ADDR_W        = 5,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [bus_width:0]   cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [bus_width:0]   rsp_rdata,
    output logic                 rsp_err,
    output logic                 wrb,
    output logic [NUM_REGS-1:0]  sel,
    output logic [bus_width:0]   dout,
    input  logic [bus_width:0]   rdin
);

    // Out-of-range strobe widths are clamped to the counter's reach.
    localparam int C_S_EFF = (STROBE_CYCLES < 1) ? 1 :
                             ((STROBE_CYCLES > RB_STROBE_MAX) ? RB_STROBE_MAX : STROBE_CYCLES);
    localparam logic [RB_CNT_W-1:0] C_LOAD = RB_CNT_W'(C_S_EFF - 1);

    rb_state_t             state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [bus_width:0]    wdata_q, wdata_d;
    logic [bus_width:0]    rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, rsp_valid_q, wrb_q;
    logic [NUM_REGS-1:0]   sel_q, sel_d;
    logic [bus_width:0]    dout_q, dout_d;
    logic                  bus_d;
    logic                  accept;
    logic                  addr_ok;
    logic                  cnt_load, cnt_en, cnt_done;

    assign accept  = cmd_valid & cmd_ready_q;
    assign addr_ok = (int'(cmd_addr) < NUM_REGS);

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (addr_ok) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                cnt_load = 1'b1;
                state_d  = write_q ? ST_STROBE : ST_WAIT;
            end
            ST_STROBE: begin
                cnt_en = 1'b1;
                if (cnt_done) state_d = ST_HOLD;
            end
`ifdef REG_MASTER_READBACK_EN
            ST_HOLD: begin
                cnt_load = 1'b1;
                state_d  = ST_VERIFY;
            end
            ST_VERIFY: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    state_d = ST_RESP;
                    rdata_d = rdin;
                    err_d   = (rdin != wdata_q);
                end
            end
`else
            ST_HOLD: begin
                state_d = ST_RESP;
                rdata_d = '0;
                err_d   = 1'b0;
            end
`endif
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    state_d = ST_RESP;
                    rdata_d = rdin;
                    err_d   = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they change on the state edge.
    always_comb begin
        bus_d  = (state_d != ST_IDLE) && (state_d != ST_RESP);
        sel_d  = bus_d ? (NUM_REGS'(1) << addr_d) : '0;
        dout_d = (bus_d && write_d) ? wdata_d : '0;
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            wrb_q       <= 1'b1;
            sel_q       <= '0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            wrb_q       <= (state_d != ST_STROBE);
            sel_q       <= sel_d;
            dout_q      <= dout_d;
        end
    end

    reg_bus_wait_cnt u_wait_cnt (
        .clk_i      (sysclk),
        .rst_ni     (reset),
        .load_i     (cnt_load),
        .load_val_i (C_LOAD),
        .en_i       (cnt_en),
        .done_o     (cnt_done)
    );

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign wrb       = wrb_q;
    assign sel       = sel_q;
    assign dout      = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: randomized self-checking bench for two reg_bus_master instances (S=1, S=3).
`default_nettype none

module tb_reg_bus_master;

    localparam int DW = 16;
    localparam int NR = 31;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n     [2];
    logic          cmd_valid [2];
    logic          cmd_ready [2];
    logic          cmd_write [2];
    logic [AW-1:0] cmd_addr  [2];
    logic [DW-1:0] cmd_wdata [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [DW-1:0] rsp_rdata [2];
    logic          rsp_err   [2];
    logic          wrb       [2];
    logic [NR-1:0] sel       [2];
    logic [DW-1:0] dout      [2];
    logic [DW-1:0] rdin      [2];

    int n_tests = 0;
    int n_fail  = 0;

    reg_bus_master #(.bus_width(15), .NUM_REGS(NR), .ADDR_W(AW), .STROBE_CYCLES(1)) u_dut_s1 (
        .sysclk(clk), .reset(rst_n[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .wrb(wrb[0]), .sel(sel[0]), .dout(dout[0]), .rdin(rdin[0])
    );

    reg_bus_master #(.bus_width(15), .NUM_REGS(NR), .ADDR_W(AW), .STROBE_CYCLES(3)) u_dut_s3 (
        .sysclk(clk), .reset(rst_n[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .wrb(wrb[1]), .sel(sel[1]), .dout(dout[1]), .rdin(rdin[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One command through DUT i (strobe width s), modelled as a timeline relative to the accept edge.
    task automatic run_cmd(input int i, input int s, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit fast, input int hold,
                           input bit force_rd, input logic [DW-1:0] fval);
        logic [DW-1:0] vals [40];
        bit            ok;
        bit            rb;
        int            lat;
        logic [NR-1:0] oh;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        bit            strobe;
`ifdef REG_MASTER_READBACK_EN
        rb = 1'b1;
`else
        rb = 1'b0;
`endif
        for (int k = 0; k < 40; k++) vals[k] = force_rd ? fval : DW'($urandom);
        ok  = (int'(a) < NR);
        lat = !ok ? 1 : (wr ? (3 + s + (rb ? s : 0)) : (2 + s));
        oh  = ok ? (NR'(1) << a) : '0;
        if (!ok) begin
            exp_rd  = '0;
            exp_err = 1'b1;
        end else if (!wr) begin
            exp_rd  = vals[1 + s];
            exp_err = 1'b0;
        end else if (rb) begin
            exp_rd  = vals[2 + 2 * s];
            exp_err = (vals[2 + 2 * s] != d);
        end else begin
            exp_rd  = '0;
            exp_err = 1'b0;
        end

        @(negedge clk);
        check("idle_cmd_ready", cmd_ready[i], 1);
        cmd_valid[i] = 1'b1;
        cmd_write[i] = wr;
        cmd_addr[i]  = a;
        cmd_wdata[i] = d;
        rsp_ready[i] = fast;
        rdin[i]      = vals[0];
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            cmd_valid[i] = 1'b0;
            strobe = ok && wr && (k >= 2) && (k <= 1 + s);
            check("sel", sel[i], (k < lat) ? oh : '0);
            check("wrb", wrb[i], !strobe);
            check("rsp_valid", rsp_valid[i], (k == lat));
            check("busy_cmd_ready", cmd_ready[i], 0);
            if (strobe) check("dout", dout[i], d);
            if (k == lat) begin
                check("rsp_rdata", rsp_rdata[i], exp_rd);
                check("rsp_err", rsp_err[i], exp_err);
            end
            rdin[i] = vals[k];
        end
        if (!fast) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                rdin[i] = DW'($urandom);
                check("stall_valid", rsp_valid[i], 1);
                check("stall_rdata", rsp_rdata[i], exp_rd);
                check("stall_err", rsp_err[i], exp_err);
                check("stall_cmd_ready", cmd_ready[i], 0);
                check("stall_sel", sel[i], 0);
            end
            rsp_ready[i] = 1'b1;
        end
        @(negedge clk);
        check("post_valid", rsp_valid[i], 0);
        check("post_cmd_ready", cmd_ready[i], 1);
        check("post_sel", sel[i], 0);
        check("post_wrb", wrb[i], 1);
        rsp_ready[i] = 1'($urandom);
    endtask

    task automatic reset_mid(input int i);
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        cmd_valid[i] = 1'b1;
        cmd_write[i] = 1'b1;
        cmd_addr[i]  = 5'd4;
        cmd_wdata[i] = 16'h5A5A;
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        @(negedge clk);
        check("rst_pre_wrb", wrb[i], 0);
        rst_n[i] = 1'b0;
        @(negedge clk);
        check("rst_wrb", wrb[i], 1);
        check("rst_sel", sel[i], 0);
        check("rst_dout", dout[i], 0);
        check("rst_cmd_ready", cmd_ready[i], 0);
        check("rst_valid", rsp_valid[i], 0);
        rst_n[i] = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", cmd_ready[i], 1);
        rsp_ready[i] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid[i], 0);
            check("rst_no_sel", sel[i], 0);
        end
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            cmd_valid[i] = 1'b0;
            cmd_write[i] = 1'b0;
            cmd_addr[i]  = '0;
            cmd_wdata[i] = '0;
            rsp_ready[i] = 1'b0;
            rdin[i]      = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_cmd_ready", cmd_ready[i], 0);
            check("reset_valid", rsp_valid[i], 0);
            check("reset_rdata", rsp_rdata[i], 0);
            check("reset_err", rsp_err[i], 0);
            check("reset_wrb", wrb[i], 1);
            check("reset_sel", sel[i], 0);
            check("reset_dout", dout[i], 0);
            rst_n[i] = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) check("release_cmd_ready", cmd_ready[i], 1);

        run_cmd(0, 1, 1'b1, 5'd1, 16'hA5A5, 1'b0, 0, 1'b0, '0);
        run_cmd(1, 3, 1'b0, 5'd0, 16'h0000, 1'b0, 0, 1'b1, 16'h1234);
        run_cmd(0, 1, 1'b0, 5'd31, 16'h0000, 1'b0, 0, 1'b0, '0);
        run_cmd(1, 3, 1'b1, 5'd31, 16'hFFFF, 1'b1, 0, 1'b0, '0);
        run_cmd(1, 3, 1'b1, 5'd30, 16'hBEEF, 1'b0, 5, 1'b0, '0);
        run_cmd(0, 1, 1'b0, 5'd7, 16'h0000, 1'b1, 0, 1'b0, '0);
        reset_mid(1);
`ifdef REG_MASTER_READBACK_EN
        run_cmd(0, 1, 1'b1, 5'd3, 16'h00FF, 1'b0, 0, 1'b1, 16'h00FE);
        run_cmd(1, 3, 1'b1, 5'd9, 16'h1357, 1'b0, 1, 1'b1, 16'h1357);
`endif
        for (int n = 0; n < 60; n++) begin
            int            i;
            logic [AW-1:0] a;
            i = n % 2;
            a = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) a = 5'd31;
            run_cmd(i, (i == 0) ? 1 : 3, 1'($urandom), a, DW'($urandom),
                    1'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0),
                    DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
